// File: rtl/issue_scoreboard_mu_if.sv
// Decode -> issue -> FU bundle for the in-order issue scoreboard.
// master: Decode / register file / FU writeback side. slave: the issue stage.
interface issue_scoreboard_mu_if #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_UNITS = 3,
    parameter int unsigned UNIT_W    = 3,
    parameter int unsigned PAYLOAD_W = 48
);
    logic                          id_valid;
    logic                          iss_ready;
    logic                          iss_stall;
    logic [5:0]                    id_op;
    logic [5:0]                    id_funct;
    logic                          id_unit_force;
    logic [UNIT_W-1:0]             id_unit_sel;
    logic [ADDR_W-1:0]             id_addra;
    logic [ADDR_W-1:0]             id_addrb;
    logic                          id_uses_b;
    logic [ADDR_W-1:0]             id_regdest;
    logic                          id_writereg;
    logic [PAYLOAD_W-1:0]          id_payload;
    logic [ADDR_W-1:0]             iss_reg_addra;
    logic [ADDR_W-1:0]             iss_reg_addrb;
    logic [DATA_W-1:0]             reg_dataa;
    logic [DATA_W-1:0]             reg_datab;
    logic                          iss_valid;
    logic [NUM_UNITS-1:0]          iss_unit;
    logic [DATA_W-1:0]             iss_rega;
    logic [DATA_W-1:0]             iss_regb;
    logic [ADDR_W-1:0]             iss_regdest;
    logic                          iss_writereg;
    logic [PAYLOAD_W-1:0]          iss_payload;
    logic [NUM_UNITS-1:0]          wb_valid;
    logic [NUM_UNITS*ADDR_W-1:0]   wb_addr;
    logic [NUM_REGS-1:0]           sb_pending;

    modport master (
        output id_valid, id_op, id_funct, id_unit_force, id_unit_sel, id_addra, id_addrb,
               id_uses_b, id_regdest, id_writereg, id_payload, reg_dataa, reg_datab,
               wb_valid, wb_addr,
        input  iss_ready, iss_stall, iss_reg_addra, iss_reg_addrb, iss_valid, iss_unit,
               iss_rega, iss_regb, iss_regdest, iss_writereg, iss_payload, sb_pending
    );

    modport slave (
        input  id_valid, id_op, id_funct, id_unit_force, id_unit_sel, id_addra, id_addrb,
               id_uses_b, id_regdest, id_writereg, id_payload, reg_dataa, reg_datab,
               wb_valid, wb_addr,
        output iss_ready, iss_stall, iss_reg_addra, iss_reg_addrb, iss_valid, iss_unit,
               iss_rega, iss_regb, iss_regdest, iss_writereg, iss_payload, sb_pending
    );
endinterface

// File: rtl/issue_scoreboard_mu.sv
// In-order issue stage: per-register pending/owner scoreboard, per-FU in-flight
// counters, RAW/WAW/capacity blocking and a registered one-hot dispatch pulse.
module issue_scoreboard_mu #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_UNITS    = 3,
    parameter int unsigned UNIT_W       = 3,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned PAYLOAD_W    = 48
) (
    input logic                 clock,
    input logic                 reset,
    issue_scoreboard_mu_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [UNIT_W-1:0]    unit_idx;
    logic [NUM_UNITS-1:0] unit_oh;
    logic                 unit_ok;
    logic                 hazard_raw;
    logic                 hazard_waw;
    logic                 at_capacity;
    logic                 ready;
    logic                 accept;

    logic [NUM_REGS-1:0]  pend_q, pend_d;
    logic [UNIT_W-1:0]    owner_q [NUM_REGS];
    logic [UNIT_W-1:0]    owner_d [NUM_REGS];
    logic [CNT_W-1:0]     infl_q [NUM_UNITS];
    logic [CNT_W-1:0]     infl_d [NUM_UNITS];

    logic                 valid_q;
    logic [NUM_UNITS-1:0] unit_q;
    logic [DATA_W-1:0]    rega_q, regb_q;
    logic [ADDR_W-1:0]    regdest_q;
    logic                 writereg_q;
    logic [PAYLOAD_W-1:0] payload_q;

    // Map the instruction to a functional unit index.
    always_comb begin
        unit_idx = '0;
        if (bus.id_unit_force) begin
            unit_idx = bus.id_unit_sel;
        end else if (bus.id_op == 6'h23 || bus.id_op == 6'h2B) begin
            unit_idx = UNIT_W'(1);
        end else if (bus.id_op == 6'h00 && bus.id_funct == 6'h18) begin
            unit_idx = UNIT_W'(2);
        end
    end

    assign unit_ok = 32'(unit_idx) < NUM_UNITS;
    assign unit_oh = NUM_UNITS'(1) << unit_idx;

    // Capacity of the target FU; an out-of-range index matches no counter.
    always_comb begin
        at_capacity = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_idx == UNIT_W'(u) && infl_q[u] == CNT_W'(MAX_INFLIGHT)) begin
                at_capacity = 1'b1;
            end
        end
    end

    // Hazards look only at registered state; a same-cycle writeback does not bypass.
    assign hazard_raw = pend_q[bus.id_addra] | (bus.id_uses_b & pend_q[bus.id_addrb]);
    assign hazard_waw = bus.id_writereg & pend_q[bus.id_regdest];
    assign ready      = unit_ok & ~hazard_raw & ~hazard_waw & ~at_capacity;
    assign accept     = bus.id_valid & ready;

    assign bus.iss_ready     = ready;
    assign bus.iss_stall     = bus.id_valid & ~ready;
    assign bus.iss_reg_addra = bus.id_addra;
    assign bus.iss_reg_addrb = bus.id_addrb;

    // Scoreboard next state: writeback clears first, then the issued destination is set.
    always_comb begin
        pend_d  = pend_q;
        owner_d = owner_q;
        for (int u = 0; u < NUM_UNITS; u++) begin
            // Only the owning FU may clear; stale addresses from others are ignored.
            if (bus.wb_valid[u] && pend_q[bus.wb_addr[u*ADDR_W +: ADDR_W]] &&
                owner_q[bus.wb_addr[u*ADDR_W +: ADDR_W]] == UNIT_W'(u)) begin
                pend_d[bus.wb_addr[u*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (accept && bus.id_writereg && bus.id_regdest != '0) begin
            pend_d[bus.id_regdest]  = 1'b1;
            owner_d[bus.id_regdest] = unit_idx;
        end
        pend_d[0] = 1'b0;
    end

    // In-flight counters: retire saturates at zero, issue on the same FU cancels it out.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            infl_d[u] = infl_q[u];
            if (bus.wb_valid[u] && infl_q[u] != '0) begin
                infl_d[u] = infl_d[u] - CNT_W'(1);
            end
            if (accept && unit_idx == UNIT_W'(u)) begin
                infl_d[u] = infl_d[u] + CNT_W'(1);
            end
        end
    end

    // Scoreboard and counter state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                owner_q[r] <= '0;
            end
            for (int u = 0; u < NUM_UNITS; u++) begin
                infl_q[u] <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            owner_q <= owner_d;
            infl_q  <= infl_d;
        end
    end

    // Dispatch register: pulse plus operands; data holds when nothing is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            unit_q     <= '0;
            rega_q     <= '0;
            regb_q     <= '0;
            regdest_q  <= '0;
            writereg_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            valid_q <= accept;
            unit_q  <= accept ? unit_oh : '0;
            if (accept) begin
                rega_q     <= bus.reg_dataa;
                regb_q     <= bus.reg_datab;
                regdest_q  <= bus.id_regdest;
                writereg_q <= bus.id_writereg;
                payload_q  <= bus.id_payload;
            end
        end
    end

    assign bus.iss_valid    = valid_q;
    assign bus.iss_unit     = unit_q;
    assign bus.iss_rega     = rega_q;
    assign bus.iss_regb     = regb_q;
    assign bus.iss_regdest  = regdest_q;
    assign bus.iss_writereg = writereg_q;
    assign bus.iss_payload  = payload_q;
    assign bus.sb_pending   = pend_q;
endmodule

// File: tb/tb_issue_scoreboard_mu.sv
// Bench for issue_scoreboard_mu: directed hazard scenarios followed by random
// traffic, all checked against a register/FU bookkeeping model.
module tb_issue_scoreboard_mu;
    localparam int NUM_REGS     = 32;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 32;
    localparam int NUM_UNITS    = 3;
    localparam int UNIT_W       = 3;
    localparam int MAX_INFLIGHT = 2;
    localparam int PAYLOAD_W    = 48;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    issue_scoreboard_mu_if #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_UNITS (NUM_UNITS),
        .UNIT_W    (UNIT_W),
        .PAYLOAD_W (PAYLOAD_W)
    ) bus ();

    issue_scoreboard_mu #(
        .NUM_REGS     (NUM_REGS),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .NUM_UNITS    (NUM_UNITS),
        .UNIT_W       (UNIT_W),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .PAYLOAD_W    (PAYLOAD_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: which registers await a result, who produces it, ops per FU.
    bit                   m_pend  [NUM_REGS];
    int                   m_owner [NUM_REGS];
    int                   m_infl  [NUM_UNITS];
    bit                   e_valid;
    logic [NUM_UNITS-1:0] e_unit;
    logic [DATA_W-1:0]    e_rega, e_regb;
    logic [ADDR_W-1:0]    e_dest;
    bit                   e_wr;
    logic [PAYLOAD_W-1:0] e_pay;

    function automatic int model_fu();
        if (bus.id_unit_force) return int'(bus.id_unit_sel);
        if (bus.id_op == 6'h23 || bus.id_op == 6'h2B) return 1;
        if (bus.id_op == 6'h00 && bus.id_funct == 6'h18) return 2;
        return 0;
    endfunction

    function automatic bit model_ready();
        int fu;
        fu = model_fu();
        if (fu >= NUM_UNITS) return 1'b0;
        if (m_pend[bus.id_addra]) return 1'b0;
        if (bus.id_uses_b && m_pend[bus.id_addrb]) return 1'b0;
        if (bus.id_writereg && m_pend[bus.id_regdest]) return 1'b0;
        if (m_infl[fu] == MAX_INFLIGHT) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NUM_REGS-1:0] model_pend_vec();
        logic [NUM_REGS-1:0] v;
        for (int r = 0; r < NUM_REGS; r++) v[r] = m_pend[r];
        return v;
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, "_iss_valid"}, bus.iss_valid, e_valid);
        check({pfx, "_iss_unit"}, bus.iss_unit, e_unit);
        check({pfx, "_iss_rega"}, bus.iss_rega, e_rega);
        check({pfx, "_iss_regb"}, bus.iss_regb, e_regb);
        check({pfx, "_iss_regdest"}, bus.iss_regdest, e_dest);
        check({pfx, "_iss_writereg"}, bus.iss_writereg, e_wr);
        check({pfx, "_iss_payload"}, bus.iss_payload, e_pay);
        check({pfx, "_sb_pending"}, bus.sb_pending, model_pend_vec());
    endtask

    // One clock: check the combinational handshake, advance the model, check outputs.
    task automatic cycle();
        bit rdy, acc, stall;
        int fu, a;
        #1;
        rdy   = model_ready();
        fu    = model_fu();
        stall = bus.id_valid && !rdy;
        check("iss_ready", bus.iss_ready, rdy);
        check("iss_stall", bus.iss_stall, stall);
        check("reg_addra", bus.iss_reg_addra, bus.id_addra);
        acc     = bus.id_valid && rdy;
        e_valid = acc;
        e_unit  = '0;
        if (acc) begin
            e_unit = NUM_UNITS'(1) << fu;
            e_rega = bus.reg_dataa;
            e_regb = bus.reg_datab;
            e_dest = bus.id_regdest;
            e_wr   = bus.id_writereg;
            e_pay  = bus.id_payload;
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (bus.wb_valid[u]) begin
                if (m_infl[u] > 0) m_infl[u]--;
                a = int'(bus.wb_addr[u*ADDR_W +: ADDR_W]);
                if (m_pend[a] && m_owner[a] == u) m_pend[a] = 1'b0;
            end
        end
        if (acc) begin
            m_infl[fu]++;
            if (bus.id_writereg && bus.id_regdest != 0) begin
                m_pend[bus.id_regdest]  = 1'b1;
                m_owner[bus.id_regdest] = fu;
            end
        end
        @(posedge clock);
        #1;
        check_outputs("clk");
    endtask

    task automatic idle();
        bus.id_valid      = 1'b0;
        bus.id_op         = '0;
        bus.id_funct      = '0;
        bus.id_unit_force = 1'b0;
        bus.id_unit_sel   = '0;
        bus.id_addra      = '0;
        bus.id_addrb      = '0;
        bus.id_uses_b     = 1'b0;
        bus.id_regdest    = '0;
        bus.id_writereg   = 1'b0;
        bus.id_payload    = '0;
        bus.reg_dataa     = '0;
        bus.reg_datab     = '0;
        bus.wb_valid      = '0;
        bus.wb_addr       = '0;
    endtask

    task automatic clear_wb();
        bus.wb_valid = '0;
        bus.wb_addr  = '0;
    endtask

    task automatic put_op(input logic [5:0] op, input logic [5:0] funct, input int a,
                          input int b, input int dest, input bit wr);
        bus.id_valid      = 1'b1;
        bus.id_op         = op;
        bus.id_funct      = funct;
        bus.id_unit_force = 1'b0;
        bus.id_unit_sel   = '0;
        bus.id_addra      = ADDR_W'(a);
        bus.id_addrb      = ADDR_W'(b);
        bus.id_uses_b     = 1'b1;
        bus.id_regdest    = ADDR_W'(dest);
        bus.id_writereg   = wr;
        bus.id_payload    = PAYLOAD_W'({$urandom(), $urandom()});
        bus.reg_dataa     = $urandom();
        bus.reg_datab     = $urandom();
    endtask

    task automatic put_wb(input int u, input int a);
        bus.wb_valid[u]                 = 1'b1;
        bus.wb_addr[u*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic apply_reset(input string pfx);
        reset = 1'b0;
        #1;
        for (int r = 0; r < NUM_REGS; r++) begin
            m_pend[r]  = 1'b0;
            m_owner[r] = 0;
        end
        for (int u = 0; u < NUM_UNITS; u++) m_infl[u] = 0;
        e_valid = 1'b0;
        e_unit  = '0;
        e_rega  = '0;
        e_regb  = '0;
        e_dest  = '0;
        e_wr    = 1'b0;
        e_pay   = '0;
        check_outputs(pfx);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int kind, nstall;
        idle();
        // Reset state.
        apply_reset("rst");

        // Reset while a dispatch is on the outputs drops it without a clock edge.
        put_op(6'h00, 6'h20, 2, 3, 7, 1'b1);
        cycle();
        check("t1_dispatch_seen", bus.iss_valid, 1'b1);
        apply_reset("t1_mid");

        // Back-to-back independent ALU ops; inflight must start from zero.
        put_op(6'h00, 6'h20, 2, 3, 1, 1'b1);
        cycle();
        put_op(6'h00, 6'h20, 5, 6, 4, 1'b1);
        cycle();
        check("t2_second_valid", bus.iss_valid, 1'b1);
        check("t2_pend_1_4", {bus.sb_pending[4], bus.sb_pending[1]}, 2'b11);
        idle();
        put_wb(0, 1);
        cycle();
        clear_wb();
        put_wb(0, 4);
        cycle();
        clear_wb();

        // RAW on a multiply result: stall until the writeback, issue one cycle later.
        put_op(6'h00, 6'h18, 2, 3, 8, 1'b1);
        cycle();
        put_op(6'h00, 6'h20, 8, 0, 12, 1'b1);
        nstall = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.iss_stall) nstall++;
            cycle();
        end
        check("t3_stall_cycles", nstall, 3);
        put_wb(2, 8);
        cycle();
        check("t3_no_bypass", bus.iss_valid, 1'b0);
        clear_wb();
        cycle();
        check("t3_issue_after_wb", bus.iss_valid, 1'b1);
        idle();
        put_wb(0, 12);
        cycle();
        clear_wb();

        // Mem capacity: third load waits for a Mem retire.
        put_op(6'h23, 6'h00, 0, 0, 9, 1'b1);
        bus.id_uses_b = 1'b0;
        cycle();
        bus.id_regdest = ADDR_W'(10);
        cycle();
        bus.id_regdest = ADDR_W'(11);
        cycle();
        check("t4_third_blocked", bus.iss_valid, 1'b0);
        put_wb(1, 9);
        cycle();
        clear_wb();
        cycle();
        check("t4_third_valid", bus.iss_valid, 1'b1);
        check("t4_third_unit", bus.iss_unit, 3'b010);
        idle();
        put_wb(1, 10);
        cycle();
        clear_wb();
        put_wb(1, 11);
        cycle();
        clear_wb();

        // Store retiring with a stale address owned by Mult.
        put_op(6'h00, 6'h18, 2, 3, 8, 1'b1);
        cycle();
        put_op(6'h2B, 6'h00, 0, 5, 8, 1'b0);
        cycle();
        idle();
        put_wb(1, 8);
        cycle();
        clear_wb();
        check("t5_r8_still_pending", bus.sb_pending[8], 1'b1);
        put_op(6'h23, 6'h00, 0, 0, 13, 1'b1);
        cycle();
        bus.id_regdest = ADDR_W'(14);
        cycle();
        check("t5_mem_freed", bus.iss_valid, 1'b1);
        idle();
        put_wb(1, 13);
        cycle();
        clear_wb();
        put_wb(1, 14);
        put_wb(2, 8);
        cycle();
        clear_wb();

        // Register 0 destination, then issue and retire on FU0 together.
        put_op(6'h00, 6'h20, 2, 3, 0, 1'b1);
        cycle();
        check("t6_r0_never_pending", bus.sb_pending[0], 1'b0);
        put_op(6'h00, 6'h20, 2, 3, 15, 1'b1);
        put_wb(0, 0);
        cycle();
        clear_wb();
        put_op(6'h00, 6'h20, 2, 3, 16, 1'b1);
        cycle();
        check("t6_second_fits", bus.iss_valid, 1'b1);
        put_op(6'h00, 6'h20, 2, 3, 17, 1'b1);
        cycle();
        check("t6_capacity_hit", bus.iss_valid, 1'b0);
        idle();
        put_wb(0, 15);
        cycle();
        clear_wb();
        put_wb(0, 16);
        cycle();
        clear_wb();

        // Random traffic; retires never exceed what each FU has in flight.
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(99) < 80) begin
                kind = $urandom_range(5);
                case (kind)
                    0:       put_op(6'h00, 6'h21, $urandom_range(7), $urandom_range(7),
                                    $urandom_range(7), 1'($urandom_range(1)));
                    1:       put_op(6'h0C, 6'($urandom), $urandom_range(7), $urandom_range(7),
                                    $urandom_range(7), 1'($urandom_range(1)));
                    2:       put_op(6'h23, 6'($urandom), $urandom_range(7), $urandom_range(7),
                                    $urandom_range(7), 1'b1);
                    3:       put_op(6'h2B, 6'($urandom), $urandom_range(7), $urandom_range(7),
                                    $urandom_range(7), 1'b0);
                    4:       put_op(6'h00, 6'h18, $urandom_range(7), $urandom_range(7),
                                    $urandom_range(7), 1'($urandom_range(1)));
                    default: begin
                        put_op(6'h23, 6'h00, $urandom_range(7), $urandom_range(7),
                               $urandom_range(7), 1'($urandom_range(1)));
                        bus.id_unit_force = 1'b1;
                        bus.id_unit_sel   = UNIT_W'($urandom_range(NUM_UNITS - 1));
                    end
                endcase
                bus.id_uses_b = 1'($urandom_range(1));
            end
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (m_infl[u] > 0 && $urandom_range(99) < 45) begin
                    int owned[$];
                    owned = {};
                    for (int r = 1; r < NUM_REGS; r++) begin
                        if (m_pend[r] && m_owner[r] == u) owned.push_back(r);
                    end
                    if (owned.size() > 0 &&
                        (owned.size() >= m_infl[u] || $urandom_range(3) != 0)) begin
                        put_wb(u, owned[$urandom_range(owned.size() - 1)]);
                    end else if (owned.size() < m_infl[u]) begin
                        put_wb(u, $urandom_range(NUM_REGS - 1));
                    end
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
